// File: rtl/replay_pkg.sv
// rtl/replay_pkg.sv - shared types and constants for the replay store
package replay_pkg;

    localparam int SEQ_W = 12;

    localparam logic [1:0] ACKNAK_NONE = 2'b00;
    localparam logic [1:0] ACKNAK_ACK  = 2'b01;
    localparam logic [1:0] ACKNAK_NAK  = 2'b10;

    typedef enum logic {
        IDLE   = 1'b0,
        REPLAY = 1'b1
    } state_t;

endpackage

// File: rtl/replay_ram.sv
// rtl/replay_ram.sv - simple dual-port memory, synchronous write, registered read
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset (read register only)
//   we_i, waddr_i, wdata_i  write port
//   re_i, raddr_i        read port; rdata_o updates only when re_i is high
//   rdata_o              registered read data
module replay_ram #(
    parameter int WIDTH = 44,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Read register holds its value while re_i is low so the replay output
    // stays stable during downstream back-pressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/replay_store.sv
// rtl/replay_store.sv - TLP replay buffer with ACK/NAK purge and replay streaming
//
// Optional feature macro: REPLAY_NUM_EN (replay counter and retrain output).
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   clr               synchronous clear, overrides everything
//   we, din           write strobe and word to store (accepted when rdy)
//   acknak, ack_seq   01=ACK, 10=NAK with the acknowledged sequence number
//   to                replay timeout strobe
//   tx_ready          downstream accepts the replay word
//   tx_valid, tx_data, tx_seq  replay stream
//   busy_n            low while replaying
//   rdy               write accepted this cycle
//   full, empty       occupancy flags
//   next_seq          sequence number of the next write
//   retrain           (REPLAY_NUM_EN only) one-cycle pulse on 4th fruitless replay
module replay_store
    import replay_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clr,
    input  logic              we,
    input  logic [DATA_W-1:0] din,
    input  logic [1:0]        acknak,
    input  logic [SEQ_W-1:0]  ack_seq,
    input  logic              to,
    input  logic              tx_ready,
    output logic              tx_valid,
    output logic [DATA_W-1:0] tx_data,
    output logic [SEQ_W-1:0]  tx_seq,
    output logic              busy_n,
    output logic              rdy,
    output logic              full,
    output logic              empty,
    output logic [SEQ_W-1:0]  next_seq
`ifdef REPLAY_NUM_EN
    ,
    output logic              retrain
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CMP_W = SEQ_W + 1;
    localparam int WORD_W = DATA_W + SEQ_W;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [SEQ_W-1:0]   next_seq_q, next_seq_d;
    logic [PTR_W-1:0]   fp_q, fp_d;      // next replay fetch address
    logic [CNT_W-1:0]   lf_q, lf_d;      // replay words still to fetch
    logic               tx_valid_q, tx_valid_d;

    logic               ram_we;
    logic               ram_re;
    logic [WORD_W-1:0]  ram_rdata;

    logic [SEQ_W-1:0]   oldest_seq;
    logic [SEQ_W-1:0]   ack_n;
    logic               purge;
    logic               wr_ok;
    logic               enter;

    // Stored sequence numbers are always consecutive, so the oldest one is
    // derived from next_seq and the occupancy instead of being read back.
    assign oldest_seq = next_seq_q - SEQ_W'(count_q);
    assign ack_n      = ack_seq - oldest_seq + SEQ_W'(1);
    assign purge      = (acknak == ACKNAK_ACK || acknak == ACKNAK_NAK) &&
                        (count_q != '0) && (ack_n != '0) &&
                        ({1'b0, ack_n} <= CMP_W'(count_q));

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign busy_n   = (state_q == IDLE);
    assign rdy      = !full && busy_n;
    assign wr_ok    = we && rdy;
    assign tx_valid = tx_valid_q;
    assign tx_data  = ram_rdata[WORD_W-1:SEQ_W];
    assign tx_seq   = ram_rdata[SEQ_W-1:0];
    assign next_seq = next_seq_q;

    replay_ram #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (reset_n),
        .we_i    (ram_we),
        .waddr_i (wr_ptr_q),
        .wdata_i ({din, next_seq_q}),
        .re_i    (ram_re),
        .raddr_i (fp_q),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        next_seq_d = next_seq_q;
        fp_d       = fp_q;
        lf_d       = lf_q;
        tx_valid_d = tx_valid_q;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        enter      = 1'b0;

        if (clr) begin
            state_d    = IDLE;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            next_seq_d = '0;
            fp_d       = '0;
            lf_d       = '0;
            tx_valid_d = 1'b0;
        end else if (state_q == IDLE) begin
            if (wr_ok) begin
                ram_we     = 1'b1;
                wr_ptr_d   = wr_ptr_q + PTR_W'(1);
                next_seq_d = next_seq_q + SEQ_W'(1);
            end
            // rdy was taken from the pre-purge count, so a full buffer still
            // drops a write that arrives with an ACK.
            count_d = count_q + CNT_W'(wr_ok) - (purge ? CNT_W'(ack_n) : CNT_W'(0));
            if (purge) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(ack_n);
            end
            // NAK wins over a simultaneous timeout.
            if (acknak == ACKNAK_NAK) begin
                enter = (count_d != '0);
            end else begin
                enter = to && !empty;
            end
            if (enter) begin
                state_d = REPLAY;
                fp_d    = rd_ptr_d;
                lf_d    = count_d;
            end
        end else begin
            // Fetch the next word whenever the output slot is free or being
            // consumed; finish once the last fetched word is accepted.
            if ((!tx_valid_q || tx_ready) && lf_q != '0) begin
                ram_re     = 1'b1;
                fp_d       = fp_q + PTR_W'(1);
                lf_d       = lf_q - CNT_W'(1);
                tx_valid_d = 1'b1;
            end else if (tx_valid_q && tx_ready) begin
                tx_valid_d = 1'b0;
                state_d    = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            next_seq_q <= '0;
            fp_q       <= '0;
            lf_q       <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            next_seq_q <= next_seq_d;
            fp_q       <= fp_d;
            lf_q       <= lf_d;
            tx_valid_q <= tx_valid_d;
        end
    end

`ifdef REPLAY_NUM_EN
    logic [1:0] rnum_q, rnum_d;
    logic [1:0] rnum_base;
    logic       retrain_q, retrain_d;

    // Any purge counts as progress and restarts the fruitless-replay count.
    always_comb begin
        rnum_base = (purge && state_q == IDLE) ? 2'd0 : rnum_q;
        rnum_d    = rnum_base;
        retrain_d = 1'b0;
        if (clr) begin
            rnum_d = 2'd0;
        end else if (enter) begin
            if (rnum_base == 2'd3) begin
                retrain_d = 1'b1;
                rnum_d    = 2'd0;
            end else begin
                rnum_d = rnum_base + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rnum_q    <= 2'd0;
            retrain_q <= 1'b0;
        end else begin
            rnum_q    <= rnum_d;
            retrain_q <= retrain_d;
        end
    end

    assign retrain = retrain_q;
`endif

endmodule

// File: tb/tb_replay_store.sv
// tb/tb_replay_store.sv - self-checking bench for replay_store
module tb_replay_store;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clr;
    logic        we;
    logic [31:0] din;
    logic [1:0]  acknak;
    logic [11:0] ack_seq;
    logic        to;
    logic        tx_ready;
    logic        tx_valid;
    logic [31:0] tx_data;
    logic [11:0] tx_seq;
    logic        busy_n;
    logic        rdy;
    logic        full;
    logic        empty;
    logic [11:0] next_seq;

    int n_checks = 0;
    int n_fail   = 0;

    logic [43:0] exp_q [$];

    replay_store #(
        .DATA_W (32),
        .DEPTH  (16)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (clr),
        .we       (we),
        .din      (din),
        .acknak   (acknak),
        .ack_seq  (ack_seq),
        .to       (to),
        .tx_ready (tx_ready),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_seq   (tx_seq),
        .busy_n   (busy_n),
        .rdy      (rdy),
        .full     (full),
        .empty    (empty),
        .next_seq (next_seq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every accepted replay word is matched against the
    // next expected {data, seq} pushed by the stimulus.
    always @(negedge clk) begin
        if (reset_n && tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_tx: got %0h/%0h expected none", tx_data, tx_seq);
            end else begin
                logic [43:0] e;
                e = exp_q.pop_front();
                chk("tx_data", tx_data, e[43:12]);
                chk("tx_seq", 32'(tx_seq), 32'(e[11:0]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] d);
        we = 1'b1;
        din = d;
        tick();
        we = 1'b0;
    endtask

    task automatic send(input logic [1:0] code, input logic [11:0] s, input logic t);
        acknak = code;
        ack_seq = s;
        to = t;
        tick();
        acknak = 2'b00;
        to = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max);
        int k = 0;
        while (busy_n !== 1'b1 && k < max) begin
            tick();
            k++;
        end
        chk(name, 32'(busy_n), 32'd1);
    endtask

    initial begin
        reset_n = 1'b0; clr = 1'b0; we = 1'b0; din = '0;
        acknak = 2'b00; ack_seq = '0; to = 1'b0; tx_ready = 1'b1;
        #3;
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", tx_data, 32'd0);
        chk("rst_tx_seq", 32'(tx_seq), 32'd0);
        chk("rst_busy_n", 32'(busy_n), 32'd1);
        chk("rst_rdy", 32'(rdy), 32'd1);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_next_seq", 32'(next_seq), 32'd0);
        tick(); tick();
        reset_n = 1'b1;
        tick();

        // A, B, C -> seq 0,1,2
        wr(32'hAAAA_0000); wr(32'hBBBB_0001); wr(32'hCCCC_0002);
        chk("abc_next_seq", 32'(next_seq), 32'd3);
        chk("abc_empty", 32'(empty), 32'd0);
        send(2'b01, 12'd1, 1'b0);
        send(2'b01, 12'd1, 1'b0);
        wr(32'hDDDD_0003);
        exp_q.push_back({32'hDDDD_0003, 12'd3});
        send(2'b10, 12'd2, 1'b0);
        chk("nak_busy_n", 32'(busy_n), 32'd0);
        chk("nak_rdy", 32'(rdy), 32'd0);
        wait_idle("nak_idle", 20);
        chk("nak_q_drained", exp_q.size(), 32'd0);
        chk("nak_empty", 32'(empty), 32'd0);
        send(2'b01, 12'd3, 1'b0);
        chk("ack3_empty", 32'(empty), 32'd1);

        // Fill seqs 4..19
        for (int i = 0; i < 16; i++) wr(32'h100 + 32'(i));
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_rdy", 32'(rdy), 32'd0);
        wr(32'hDEAD_BEEF);
        chk("drop_next_seq", 32'(next_seq), 32'd20);
        we = 1'b1; din = 32'hDEAD_0001;
        send(2'b01, 12'd4, 1'b0);
        we = 1'b0;
        chk("full_ack_next_seq", 32'(next_seq), 32'd20);
        chk("full_ack_full", 32'(full), 32'd0);
        send(2'b01, 12'd19, 1'b0);
        chk("ack_all_empty", 32'(empty), 32'd1);

        // Timeout replay with back-pressure
        wr(32'hEEEE_0020); wr(32'hFFFF_0021);
        exp_q.push_back({32'hEEEE_0020, 12'd20});
        exp_q.push_back({32'hFFFF_0021, 12'd21});
        tx_ready = 1'b0;
        send(2'b00, 12'd0, 1'b1);
        chk("to_busy_n", 32'(busy_n), 32'd0);
        chk("to_valid_delay", 32'(tx_valid), 32'd0);
        tick();
        chk("to_valid", 32'(tx_valid), 32'd1);
        chk("to_seq", 32'(tx_seq), 32'd20);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_data", tx_data, 32'hEEEE_0020);
        end
        tx_ready = 1'b1;
        wait_idle("to_idle", 20);
        chk("to_q_drained", exp_q.size(), 32'd0);
        chk("to_no_purge", 32'(empty), 32'd0);

        // Reset in the middle of a replay
        tx_ready = 1'b0;
        send(2'b00, 12'd0, 1'b1);
        tick();
        chk("mid_valid", 32'(tx_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(tx_valid), 32'd0);
        tick();
        reset_n = 1'b1;
        tick(); tick();
        chk("post_rst_valid", 32'(tx_valid), 32'd0);
        chk("post_rst_busy_n", 32'(busy_n), 32'd1);
        chk("post_rst_empty", 32'(empty), 32'd1);
        tx_ready = 1'b1;

        // Clear overrides a simultaneous write
        wr(32'h1234_5678);
        we = 1'b1; din = 32'h1;
        clr = 1'b1;
        tick();
        clr = 1'b0; we = 1'b0;
        chk("clr_next_seq", 32'(next_seq), 32'd0);
        chk("clr_empty", 32'(empty), 32'd1);

        // Sequence wrap
        for (int i = 0; i < 4094; i++) begin
            wr(32'(i));
            send(2'b01, 12'(i), 1'b0);
        end
        chk("pre_wrap_seq", 32'(next_seq), 32'd4094);
        wr(32'hCAFE_0000); wr(32'hCAFE_0001);
        chk("wrap_seq", 32'(next_seq), 32'd0);
        wr(32'hCAFE_0002); wr(32'hCAFE_0003);
        chk("post_wrap_seq", 32'(next_seq), 32'd2);
        send(2'b01, 12'd0, 1'b0);
        exp_q.push_back({32'hCAFE_0003, 12'd1});
        send(2'b00, 12'd0, 1'b1);
        wait_idle("wrap_idle", 20);
        chk("wrap_q_drained", exp_q.size(), 32'd0);
        // NAK freeing the last entry wins over timeout: no replay
        send(2'b10, 12'd1, 1'b1);
        chk("nakto_busy_n", 32'(busy_n), 32'd1);
        chk("nakto_empty", 32'(empty), 32'd1);

        tick(); tick();
        chk("final_q_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
